// File: rtl/regfile_wb.sv
// Integer register file at the MEM/WB writeback boundary: two combinational read
// ports with same-cycle writeback bypass, plus a pending-load scoreboard driving stall_req.
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              sb_flush,
    output logic              stall_req
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_wr_en;
    logic                w_byp1;
    logic                w_byp2;

    assign w_wr_en = wb_wreg && (wb_wd != '0);
    assign w_byp1  = wb_wreg && (wb_wd == raddr1);
    assign w_byp2  = wb_wreg && (wb_wd == raddr2);

    // Set is applied after clear so a freshly issued load wins over the retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (sb_flush) begin
            w_busy_next = '0;
        end else begin
            if (w_wr_en) w_busy_next[wb_wd] = 1'b0;
            if (sb_set && (sb_addr != '0)) w_busy_next[sb_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_en) r_regs[wb_wd] <= wb_wdata;
            r_busy <= w_busy_next;
        end
    end

    always_comb begin
        rdata1    = '0;
        rdata2    = '0;
        stall_req = 1'b0;
        if (!rst) begin
            if (re1 && (raddr1 != '0)) rdata1 = w_byp1 ? wb_wdata : r_regs[raddr1];
            if (re2 && (raddr2 != '0)) rdata2 = w_byp2 ? wb_wdata : r_regs[raddr2];
            stall_req = (re1 && r_busy[raddr1] && !w_byp1) ||
                        (re2 && r_busy[raddr2] && !w_byp2);
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a reference model predicts each cycle's read data
// and stall; predictions are queued when driven and compared on the falling edge.
module tb_regfile_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              sb_flush;
    logic              stall_req;

    regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic              st;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_busy;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input logic re, input logic [ADDR_W-1:0] a);
        if (rst || !re || a == '0) return '0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic s1, s2;
        if (rst) return 1'b0;
        s1 = re1 && m_busy[raddr1] && !(wb_wreg && wb_wd == raddr1);
        s2 = re2 && m_busy[raddr2] && !(wb_wreg && wb_wd == raddr2);
        return s1 || s2;
    endfunction

    task automatic m_update();
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (wb_wreg && wb_wd != '0) m_regs[wb_wd] = wb_wdata;
            if (sb_flush) m_busy = '0;
            else begin
                if (wb_wreg && wb_wd != '0) m_busy[wb_wd] = 1'b0;
                if (sb_set && sb_addr != '0) m_busy[sb_addr] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
    endtask

    // Inputs are already driven; predict, compare on negedge, then advance the model.
    task automatic step(input string tag);
        exp_t e;
        e.tag = tag;
        e.r1  = m_read(re1, raddr1);
        e.r2  = m_read(re2, raddr2);
        e.st  = m_stall();
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val({e.tag, ".rdata1"}, rdata1, e.r1);
        check_val({e.tag, ".rdata2"}, rdata2, e.r2);
        check_val({e.tag, ".stall"}, {31'd0, stall_req}, {31'd0, e.st});
        @(posedge clk);
        m_update();
        #1;
        idle();
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_wreg = 1'b1; wb_wd = a; wb_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 'x;
        m_busy = 'x;
        idle();
        rst = 1'b1; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd9;
        @(posedge clk); m_update(); #1;
        rst = 1'b1; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd9;
        step("rst_held");

        for (int i = 1; i < NUM_REGS; i++) begin
            re1 = 1'b1; raddr1 = i[ADDR_W-1:0]; re2 = 1'b1; raddr2 = i[ADDR_W-1:0];
            step("reset_read");
        end

        wr(5'd5, 32'hDEADBEEF); step("wr_x5");
        re1 = 1'b1; raddr1 = 5'd5; step("rd_x5");
        wr(5'd0, 32'h1234); step("wr_x0");
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; step("rd_x0");
        wr(5'd0, 32'h1234); re2 = 1'b1; raddr2 = 5'd0; step("byp_x0");

        wr(5'd7, 32'hA5A5A5A5); re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        step("bypass_x7");
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd5; step("rd_x7");

        sb_set = 1'b1; sb_addr = 5'd3; step("load_x3");
        re2 = 1'b1; raddr2 = 5'd3; step("use_x3");
        re2 = 1'b1; raddr2 = 5'd3; wr(5'd3, 32'h55); step("wb_x3");
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3; step("after_x3");

        sb_set = 1'b1; sb_addr = 5'd4; step("load_x4");
        sb_set = 1'b1; sb_addr = 5'd4; wr(5'd4, 32'h44); step("collide_x4");
        re1 = 1'b1; raddr1 = 5'd4; step("busy_x4");
        sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd6; re2 = 1'b1; raddr2 = 5'd4;
        step("flush");
        re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd6; step("post_flush");

        sb_set = 1'b1; sb_addr = 5'd9; step("load_x9");
        re1 = 1'b0; raddr1 = 5'd9; step("re_gate");
        re2 = 1'b1; raddr2 = 5'd9; step("busy_x9_p2");

        sb_set = 1'b1; sb_addr = 5'd10; wr(5'd11, 32'hCAFEF00D); step("pre_rst");
        rst = 1'b1; wr(5'd12, 32'h12); re1 = 1'b1; raddr1 = 5'd11; step("mid_rst");
        re1 = 1'b1; raddr1 = 5'd10; re2 = 1'b1; raddr2 = 5'd11; step("after_rst");
        wr(5'd12, 32'h77); step("wr_after_rst");
        re1 = 1'b1; raddr1 = 5'd12; step("rd_after_rst");

        for (int n = 0; n < 300; n++) begin
            rst      = ($urandom_range(63) == 0);
            wb_wreg  = $urandom_range(1);
            wb_wd    = ADDR_W'($urandom_range(7));
            wb_wdata = $urandom;
            re1      = $urandom_range(3) != 0;
            raddr1   = ADDR_W'($urandom_range(7));
            re2      = $urandom_range(3) != 0;
            raddr2   = ADDR_W'($urandom_range(7));
            sb_set   = $urandom_range(1);
            sb_addr  = ADDR_W'($urandom_range(7));
            sb_flush = ($urandom_range(15) == 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
